// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types for the master bridge: response codes, FSM states and the
// read data returned when a transaction is abandoned on timeout.
package axi4l_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } state_e;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/axi4l_master_bridge_if.sv
// AXI4-Lite bus (32-bit data) between the bridge and a register slave.
// The master modport is the bridge side.
interface axi4l_master_bridge_if #(
    parameter int AW = 32
);
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4l_master_bridge.sv
// Single-outstanding request/response to AXI4-Lite master bridge.
// Optional abort of stalled transactions with `define AXI4L_MASTER_TIMEOUT_EN.
module axi4l_master_bridge
    import axi4l_pkg::*;
#(
    parameter int AW             = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [AW-1:0]         req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    axi4l_master_bridge_if.master m_axi
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_e        state;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          write_q;
    logic          awvalid_q;
    logic          wvalid_q;
    logic          bready_q;
    logic          arvalid_q;
    logic          rready_q;
    logic [31:0]   rdata_q;
    axi_resp_e     resp_q;
`ifdef AXI4L_MASTER_TIMEOUT_EN
    logic [31:0]   tmo_cnt;
`endif

    // Every AXI output comes straight from a flop, so no valid can follow a ready.
    assign m_axi.awaddr  = addr_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    assign rsp_write = write_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            // NOTE: payload registers are reset too because they drive ports that must read 0 in reset.
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= OKAY;
`ifdef AXI4L_MASTER_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments only, so every branch sees pre-edge values.
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        wstrb_q   <= req_wstrb;
                        write_q   <= req_write;
                        if (req_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WR_AW_W;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RD_AR;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WR_AW_W: begin
                    // A dropped valid doubles as the "channel done" flag.
                    if (awvalid_q && m_axi.awready) awvalid_q <= 1'b0;
                    if (wvalid_q && m_axi.wready)   wvalid_q  <= 1'b0;
                    if ((!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready)) begin
                        bready_q <= 1'b1;
                        state    <= WR_B;
                    end
                end
                WR_B: begin
                    if (m_axi.bvalid) begin
                        bready_q <= 1'b0;
                        resp_q   <= axi_resp_e'(m_axi.bresp);
                        rdata_q  <= '0;
                        state    <= RSP;
                    end
                end
                RD_AR: begin
                    if (m_axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_R;
                    end
                end
                RD_R: begin
                    if (m_axi.rvalid) begin
                        rready_q <= 1'b0;
                        rdata_q  <= m_axi.rdata;
                        resp_q   <= axi_resp_e'(m_axi.rresp);
                        state    <= RSP;
                    end
                end
                RSP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

`ifdef AXI4L_MASTER_TIMEOUT_EN
            if (state == IDLE) begin
                tmo_cnt <= '0;
            end else if (state != RSP) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end
            // Abort overrides whatever the channel logic above decided this cycle.
            if (state != IDLE && state != RSP && tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                awvalid_q <= 1'b0;
                wvalid_q  <= 1'b0;
                bready_q  <= 1'b0;
                arvalid_q <= 1'b0;
                rready_q  <= 1'b0;
                resp_q    <= DECERR;
                rdata_q   <= TIMEOUT_RDATA;
                state     <= RSP;
            end
`endif
        end
    end

endmodule

// File: tb/tb_axi4l_master_bridge.sv
// Self-checking bench for axi4l_master_bridge: directed scenarios plus randomized traffic
// against a word-level memory model; the timeout scenario runs with AXI4L_MASTER_TIMEOUT_EN.
module tb_axi4l_master_bridge;
    import axi4l_pkg::*;

    localparam int AW = 32;
`ifdef AXI4L_MASTER_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic          clk = 1'b0;
    logic          aresetn;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;

    int checks = 0;
    int errors = 0;
    int lat;

    axi4l_master_bridge_if #(.AW(AW)) bus ();

    axi4l_master_bridge #(.AW(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .aclk      (clk),
        .aresetn   (aresetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .m_axi     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave behaviour: addresses >= 0x100 answer SLVERR, reads there return 0xE000_0000|addr.
    function automatic bit is_err(input logic [31:0] a);
        return a >= 32'h100;
    endfunction

    // ---------------- slave model (acts on the falling edge) ----------------
    int  aw_wait, w_wait, ar_wait, b_wait, r_wait;
    bit  ar_never;
    int  aw_hs, w_hs, ar_hs, b_hs, r_hs;
    bit  aw_got, w_got, ar_got, b_next, r_next;
    int  aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit  aw_pend, w_pend, ar_pend;
    logic [31:0] s_awaddr, s_wdata, s_araddr, p_awaddr, p_wdata, p_araddr;
    logic [3:0]  s_wstrb, p_wstrb;
    logic [31:0] smem [int unsigned];

    always @(negedge clk) begin
        if (!aresetn) begin
            bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
            bus.bvalid = 1'b0; bus.bresp = 2'b00;
            bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rdata = '0;
            aw_got = 0; w_got = 0; ar_got = 0; b_next = 0; r_next = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            aw_pend = 0; w_pend = 0; ar_pend = 0;
        end else begin
            if (b_next) begin bus.bvalid = 1'b0; b_next = 0; end
            if (aw_got && w_got && !bus.bvalid) begin
                if (b_cnt >= b_wait) begin
                    bus.bvalid = 1'b1;
                    bus.bresp  = is_err(s_awaddr) ? 2'b10 : 2'b00;
                    if (!is_err(s_awaddr)) begin
                        logic [31:0] v;
                        v = smem.exists(s_awaddr >> 2) ? smem[s_awaddr >> 2] : 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (s_wstrb[b]) v[8*b +: 8] = s_wdata[8*b +: 8];
                        smem[s_awaddr >> 2] = v;
                    end
                    aw_got = 0; w_got = 0; b_cnt = 0;
                end else b_cnt++;
            end
            if (bus.bvalid && bus.bready) begin b_next = 1; b_hs++; end

            if (aw_pend) begin
                check("aw_valid_held", bus.awvalid, 1);
                check("aw_addr_stable", bus.awaddr, p_awaddr);
            end
            bus.awready = bus.awvalid && !aw_got && (aw_cnt >= aw_wait);
            if (bus.awready) begin
                aw_got = 1; s_awaddr = bus.awaddr; aw_cnt = 0; aw_hs++;
                check("awprot", bus.awprot, 0);
            end else if (bus.awvalid) aw_cnt++;
            aw_pend = bus.awvalid && !bus.awready; p_awaddr = bus.awaddr;

            if (w_pend) begin
                check("w_valid_held", bus.wvalid, 1);
                check("w_data_stable", {bus.wstrb, bus.wdata}, {p_wstrb, p_wdata});
            end
            bus.wready = bus.wvalid && !w_got && (w_cnt >= w_wait);
            if (bus.wready) begin
                w_got = 1; s_wdata = bus.wdata; s_wstrb = bus.wstrb; w_cnt = 0; w_hs++;
            end else if (bus.wvalid) w_cnt++;
            w_pend = bus.wvalid && !bus.wready; p_wdata = bus.wdata; p_wstrb = bus.wstrb;

            if (r_next) begin bus.rvalid = 1'b0; r_next = 0; end
            if (ar_got && !bus.rvalid) begin
                if (r_cnt >= r_wait) begin
                    bus.rvalid = 1'b1;
                    bus.rresp  = is_err(s_araddr) ? 2'b10 : 2'b00;
                    bus.rdata  = is_err(s_araddr) ? (32'hE000_0000 | s_araddr)
                               : (smem.exists(s_araddr >> 2) ? smem[s_araddr >> 2] : 32'h0);
                    ar_got = 0; r_cnt = 0;
                end else r_cnt++;
            end
            if (bus.rvalid && bus.rready) begin r_next = 1; r_hs++; end

            if (ar_pend && !ar_never) begin
                check("ar_valid_held", bus.arvalid, 1);
                check("ar_addr_stable", bus.araddr, p_araddr);
            end
            bus.arready = bus.arvalid && !ar_got && !ar_never && (ar_cnt >= ar_wait);
            if (bus.arready) begin
                ar_got = 1; s_araddr = bus.araddr; ar_cnt = 0; ar_hs++;
                check("arprot", bus.arprot, 0);
            end else if (bus.arvalid) ar_cnt++;
            ar_pend = bus.arvalid && !bus.arready; p_araddr = bus.araddr;
        end
    end

    // ---------------- reference model: plain word memory ----------------
    logic [31:0] rmem [int unsigned];

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (is_err(a)) return 32'hE000_0000 | a;
        return rmem.exists(a / 4) ? rmem[a / 4] : 32'h0;
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m, old;
        if (is_err(a)) return;
        m   = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        old = rmem.exists(a / 4) ? rmem[a / 4] : 32'h0;
        rmem[a / 4] = (old & ~m) | (d & m);
    endfunction

    // ---------------- request / response helpers ----------------
    task automatic clear_hs();
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
    endtask

    task automatic check_hs(input bit w);
        check("aw_handshakes", aw_hs, w ? 1 : 0);
        check("w_handshakes",  w_hs,  w ? 1 : 0);
        check("b_handshakes",  b_hs,  w ? 1 : 0);
        check("ar_handshakes", ar_hs, w ? 0 : 1);
        check("r_handshakes",  r_hs,  w ? 0 : 1);
    endtask

    // Returns at the falling edge of the cycle after the request handshake (lat = 1).
    task automatic start_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input bit keep);
        int n = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        check("req_accept_wait", req_ready, 1);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
        lat = 1;
    endtask

    task automatic get_rsp(input bit ew, input logic [31:0] ed, input logic [1:0] er,
                           input int hold, input bit chk_lat);
        int n = 0;
        while (!rsp_valid && n < 200) begin
            check("busy_req_ready", req_ready, 0);
            @(negedge clk); lat++; n++;
        end
        check("rsp_valid_wait", rsp_valid, 1);
        if (chk_lat) check("rsp_latency", lat, 4);
        check("rsp_write", rsp_write, ew);
        check("rsp_rdata", rsp_rdata, ed);
        check("rsp_resp", rsp_resp, er);
        check("axi_quiet_in_rsp", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_payload", {rsp_write, rsp_rdata, rsp_resp}, {ew, ed, er});
            check("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_dropped", rsp_valid, 0);
        check("req_ready_back", req_ready, 1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int hold, input bit chk_lat);
        ref_write(a, d, s);
        clear_hs();
        start_req(1'b1, a, d, s, 1'b0);
        get_rsp(1'b1, 32'h0, is_err(a) ? 2'b10 : 2'b00, hold, chk_lat);
        check_hs(1'b1);
    endtask

    task automatic do_read(input logic [31:0] a, input int hold, input bit chk_lat);
        logic [31:0] exp;
        exp = ref_read(a);
        clear_hs();
        start_req(1'b0, a, 32'h0, 4'h0, 1'b0);
        get_rsp(1'b0, exp, is_err(a) ? 2'b10 : 2'b00, hold, chk_lat);
        check_hs(1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
                              bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 0);
        check({tag, "_addr"}, {bus.awaddr, bus.araddr}, 0);
        check({tag, "_wdata"}, {bus.wstrb, bus.wdata, bus.awprot, bus.arprot}, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        bit          w;
        int          hold;

        aresetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0; ar_never = 0;
        clear_hs();

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        aresetn = 1'b1;
        @(negedge clk);
        check("req_ready_after_reset", req_ready, 1);

        // 1: single write against an always-ready slave
        do_write(32'h4, 32'h1234_5678, 4'hF, 0, 1'b1);
        // 2: read it back
        do_read(32'h4, 0, 1'b1);

        // 3: W lags AW, then AW lags W
        aw_wait = 0; w_wait = 3;
        do_write(32'h8, 32'hCAFE_0001, 4'hF, 0, 1'b0);
        aw_wait = 3; w_wait = 0;
        do_write(32'hC, 32'hCAFE_0002, 4'h5, 0, 1'b0);
        aw_wait = 0;
        do_read(32'hC, 0, 1'b0);

        // 4: response held off while a second request waits
        clear_hs();
        start_req(1'b0, 32'h8, 32'h0, 4'h0, 1'b1);
        req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hA5A5_5A5A; req_wstrb = 4'h3;
        get_rsp(1'b0, ref_read(32'h8), 2'b00, 5, 1'b1);
        check_hs(1'b0);
        ref_write(32'h10, 32'hA5A5_5A5A, 4'h3);
        clear_hs();
        start_req(1'b1, 32'h10, 32'hA5A5_5A5A, 4'h3, 1'b0);
        get_rsp(1'b1, 32'h0, 2'b00, 0, 1'b0);
        check_hs(1'b1);
        do_read(32'h10, 0, 1'b1);

        // 5: error response passed through, then reset while waiting for R
        do_read(32'h108, 1, 1'b1);
        r_wait = 20;
        start_req(1'b0, 32'h10C, 32'h0, 4'h0, 1'b0);
        repeat (3) @(negedge clk);
        check("in_rd_r", bus.rready, 1);
        aresetn = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(negedge clk);
        aresetn = 1'b1; r_wait = 0;
        @(negedge clk);
        check("req_ready_after_mid_reset", req_ready, 1);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 7)) * 4;
            if ($urandom_range(0, 4) == 0) a = a + 32'h100;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3);
            ar_wait = $urandom_range(0, 3); b_wait = $urandom_range(0, 3);
            r_wait  = $urandom_range(0, 3);
            hold = $urandom_range(0, 2);
            if (w) do_write(a, d, s, hold, (aw_wait + w_wait + b_wait) == 0);
            else   do_read(a, hold, (ar_wait + r_wait) == 0);
        end
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;

`ifdef AXI4L_MASTER_TIMEOUT_EN
        // 6: slave never accepts the read address
        ar_never = 1;
        clear_hs();
        start_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        while (lat < 17) begin
            @(negedge clk); lat++;
            if (lat == 16) check("tmo_arvalid_before", bus.arvalid, 1);
            if (lat == 17) check("tmo_arvalid_after", bus.arvalid, 0);
        end
        get_rsp(1'b0, 32'hDEAD_BEEF, 2'b11, 1, 1'b0);
        check("tmo_ar_handshakes", ar_hs, 0);
        ar_never = 0;
        do_read(32'h4, 0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
